// File: rtl/instr_fetch_queue_pkg.sv
// Shared decode field widths and fetch FSM encoding for the instruction fetch front end.
package instr_fetch_queue_pkg;

  localparam int unsigned OP_CODE_LEN = 6;
  localparam int unsigned FUNCT_LEN   = 6;

  typedef enum logic {
    FETCH_S_RUN   = 1'b0,
    FETCH_S_DRAIN = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_queue_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with push, pop and clear; head is read straight from storage registers.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL) || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// In-order instruction fetch with a credit-limited request stream, a {pc, instr} buffer
// toward decode, and flush/restart on redirect with draining of stale responses.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [31:0]            imem_rdata,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [31:0]            dec_instr,
  output logic [31:0]            dec_pc,
  output logic [OP_CODE_LEN-1:0] dec_opcode,
  output logic [FUNCT_LEN-1:0]   dec_funct
);

  localparam int unsigned CW         = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(DEPTH);

  logic [31:0]  pc_q, pc_d;
  logic [CW-1:0] discard_q, discard_d;
  fetch_state_e state_q, state_d;

  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [63:0]   head;
  logic [31:0]   addr_head;
  logic [CW:0]   credit;
  logic          grant, rvalid_ok, push, pop;

  always_comb begin
    credit    = {1'b0, count} + {1'b0, inflight} - {1'b0, discard_q};
    imem_req  = !rst && !redirect && (credit < CREDIT_MAX);
    imem_addr = pc_q;
    grant     = imem_req && imem_gnt;
    rvalid_ok = imem_rvalid && (inflight != '0);
    dec_valid = (count != '0);
    pop       = dec_valid && dec_ready;
    push      = rvalid_ok && (state_q == FETCH_S_RUN) && !redirect;

    pc_d = pc_q;
    if (grant)    pc_d = pc_q + 32'd4;
    if (redirect) pc_d = redirect_pc;

    // A redirect dooms everything still outstanding, so the drain count is reloaded
    // from the in-flight total rather than accumulated onto an older drain.
    discard_d = discard_q;
    if (rvalid_ok && (state_q == FETCH_S_DRAIN)) discard_d = discard_q - 1'b1;
    if (redirect) discard_d = inflight - CW'(rvalid_ok);

    state_d = (discard_d != '0) ? FETCH_S_DRAIN : FETCH_S_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      discard_q <= '0;
      state_q   <= FETCH_S_RUN;
    end else begin
      pc_q      <= pc_d;
      discard_q <= discard_d;
      state_q   <= state_d;
    end
  end

  fetch_fifo #(
    .WIDTH (64),
    .DEPTH (DEPTH)
  ) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (push),
    .push_data ({addr_head, imem_rdata}),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Occupancy of this queue is the in-flight count; doomed addresses stay queued
  // and are popped as their responses return, keeping it aligned with memory order.
  fetch_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (grant),
    .push_data (pc_q),
    .pop       (rvalid_ok),
    .head      (addr_head),
    .count     (inflight)
  );

  assign dec_pc     = head[63:32];
  assign dec_instr  = head[31:0];
  assign dec_opcode = head[31:26];
  assign dec_funct  = head[5:0];

endmodule
